// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the execute stage.
//   - alu_op encodings and R-type funct constants
//   - alu_ctrl_e: 4-bit internal ALU control code
//   - FSM state encodings for alu_exec_unit
//   - alu_decode(): {alu_op, funct} -> control code plus MDU signedness
package alu_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;

    // Signed/unsigned multiply and divide share one code each; the
    // signedness travels separately so the set fits in 4 bits.
    typedef enum logic [3:0] {
        CTRL_ADD  = 4'd0,
        CTRL_SUB  = 4'd1,
        CTRL_AND  = 4'd2,
        CTRL_OR   = 4'd3,
        CTRL_XOR  = 4'd4,
        CTRL_NOR  = 4'd5,
        CTRL_SLT  = 4'd6,
        CTRL_SLTU = 4'd7,
        CTRL_SLL  = 4'd8,
        CTRL_SRL  = 4'd9,
        CTRL_SRA  = 4'd10,
        CTRL_MFHI = 4'd11,
        CTRL_MFLO = 4'd12,
        CTRL_MUL  = 4'd13,
        CTRL_DIV  = 4'd14
    } alu_ctrl_e;

    typedef struct packed {
        alu_ctrl_e ctrl;
        logic      mdu_signed;
    } alu_dec_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;

    function automatic alu_dec_t alu_decode(input logic [1:0] alu_op, input logic [5:0] funct);
        alu_dec_t d;
        d.ctrl       = CTRL_ADD;
        d.mdu_signed = 1'b0;
        case (alu_op)
            ALUOP_ADD, ALUOP_RSVD: d.ctrl = CTRL_ADD;
            ALUOP_SUB:             d.ctrl = CTRL_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FN_ADD:   d.ctrl = CTRL_ADD;
                    FN_SUB:   d.ctrl = CTRL_SUB;
                    FN_AND:   d.ctrl = CTRL_AND;
                    FN_OR:    d.ctrl = CTRL_OR;
                    FN_XOR:   d.ctrl = CTRL_XOR;
                    FN_NOR:   d.ctrl = CTRL_NOR;
                    FN_SLT:   d.ctrl = CTRL_SLT;
                    FN_SLTU:  d.ctrl = CTRL_SLTU;
                    FN_SLL:   d.ctrl = CTRL_SLL;
                    FN_SRL:   d.ctrl = CTRL_SRL;
                    FN_SRA:   d.ctrl = CTRL_SRA;
                    FN_MFHI:  d.ctrl = CTRL_MFHI;
                    FN_MFLO:  d.ctrl = CTRL_MFLO;
                    FN_MULT:  begin d.ctrl = CTRL_MUL; d.mdu_signed = 1'b1; end
                    FN_MULTU: d.ctrl = CTRL_MUL;
                    FN_DIV:   begin d.ctrl = CTRL_DIV; d.mdu_signed = 1'b1; end
                    FN_DIVU:  d.ctrl = CTRL_DIV;
                    default:  d.ctrl = CTRL_ADD;
                endcase
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/alu_exec_unit_mdu_iter.sv
// mdu_iter: iterative multiply/divide datapath, one bit per step.
//   start_i      load operands (magnitudes for signed forms) and arm WIDTH steps
//   is_div_i     1 = restoring divide, 0 = shift-add multiply
//   is_signed_i  signed form
//   a_i, b_i     operands (multiplicand/multiplier or dividend/divisor)
//   step_i       perform one iteration
//   last_o       the next step is the final one
//   hi_o, lo_o   sign-corrected HI/LO as they will be after the final step
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             is_div_i,
    input  logic             is_signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             step_i,
    output logic             last_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    import alu_pkg::*;

    localparam int CNT_W = $clog2(WIDTH) + 1;

    // Multiply: hi_q accumulates, lo_q shifts the multiplier out and product bits in.
    // Divide:   hi_q is the partial remainder, lo_q shifts dividend out and quotient in.
    logic [WIDTH-1:0] hi_q, lo_q, opb_q, dvd_q;
    logic [CNT_W-1:0] cnt_q;
    logic             is_div_q, neg_lo_q, neg_hi_q, div0_q;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum, div_shift, div_diff;
    logic [WIDTH-1:0] hi_n, lo_n;
    logic [2*WIDTH-1:0] prod;

    assign a_neg = is_signed_i & a_i[WIDTH-1];
    assign b_neg = is_signed_i & b_i[WIDTH-1];
    assign a_mag = a_neg ? -a_i : a_i;
    assign b_mag = b_neg ? -b_i : b_i;

    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    assign div_shift = {hi_q, lo_q[WIDTH-1]};
    // Bit WIDTH of the difference is the borrow: set means "restore".
    assign div_diff  = div_shift - {1'b0, opb_q};

    always_comb begin
        if (is_div_q) begin
            if (!div_diff[WIDTH]) begin
                hi_n = div_diff[WIDTH-1:0];
                lo_n = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_n = div_shift[WIDTH-1:0];
                lo_n = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_n = mul_sum[WIDTH:1];
            lo_n = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
    end

    assign prod = neg_lo_q ? -{hi_n, lo_n} : {hi_n, lo_n};

    always_comb begin
        if (!is_div_q) begin
            {hi_o, lo_o} = prod;
        end else if (div0_q) begin
            hi_o = dvd_q;
            lo_o = '1;
        end else begin
            // Quotient sign from the operand signs, remainder follows the dividend.
            lo_o = neg_lo_q ? -lo_n : lo_n;
            hi_o = neg_hi_q ? -hi_n : hi_n;
        end
    end

    assign last_o = (cnt_q == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q     <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            dvd_q    <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
        end else if (start_i) begin
            hi_q     <= '0;
            lo_q     <= is_div_i ? a_mag : b_mag;
            opb_q    <= is_div_i ? b_mag : a_mag;
            dvd_q    <= a_i;
            cnt_q    <= CNT_W'(WIDTH);
            is_div_q <= is_div_i;
            neg_lo_q <= a_neg ^ b_neg;
            neg_hi_q <= a_neg;
            div0_q   <= is_div_i && (b_i == '0);
        end else if (step_i) begin
            hi_q  <= hi_n;
            lo_q  <= lo_n;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute stage with single-cycle ALU and iterative MDU into HI/LO.
//   clk, rst_n               clock, async active-low reset
//   in_valid/in_ready        op handshake; alu_op, funct, shamt, src_a, src_b
//   out_valid/out_ready      result handshake; result, wr_en, zero, ovf
//
// state   | meaning
// IDLE    | accepting ops; single-cycle ops complete here
// MUL     | shift-add multiply running, WIDTH steps
// DIV     | restoring divide running, WIDTH steps
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         alu_op,
    input  logic [5:0]         funct,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [WIDTH-1:0]   src_a,
    input  logic [WIDTH-1:0]   src_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               wr_en,
    output logic               zero,
    output logic               ovf
);

    alu_dec_t         dec;
    logic [1:0]       state_q, state_d;
    logic             accept, stall, is_mdu_op, is_div_op;
    logic             mdu_start, mdu_step, mdu_done, mdu_last;
    logic [WIDTH-1:0] mdu_hi, mdu_lo;
    logic [WIDTH-1:0] hi_q, lo_q;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             wr_en_q, wr_en_d, zero_q, zero_d, ovf_q, ovf_d;

    logic [WIDTH-1:0] sum, diff, alu_res;
    logic             alu_ovf;

    assign dec       = alu_decode(alu_op, funct);
    assign is_div_op = (dec.ctrl == CTRL_DIV);
    assign is_mdu_op = (dec.ctrl == CTRL_MUL) || is_div_op;
    assign stall     = out_valid_q && !out_ready;
    assign accept    = in_valid && in_ready;
    assign mdu_start = accept && is_mdu_op;

    // Single-cycle ALU
    assign sum  = src_a + src_b;
    assign diff = src_a - src_b;

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (dec.ctrl)
            CTRL_ADD: begin
                alu_res = sum;
                alu_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
            end
            CTRL_SUB: begin
                alu_res = diff;
                alu_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);
            end
            CTRL_AND:  alu_res = src_a & src_b;
            CTRL_OR:   alu_res = src_a | src_b;
            CTRL_XOR:  alu_res = src_a ^ src_b;
            CTRL_NOR:  alu_res = ~(src_a | src_b);
            CTRL_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            CTRL_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            CTRL_SLL:  alu_res = src_b << shamt;
            CTRL_SRL:  alu_res = src_b >> shamt;
            CTRL_SRA:  alu_res = $signed(src_b) >>> shamt;
            CTRL_MFHI: alu_res = hi_q;
            CTRL_MFLO: alu_res = lo_q;
            default:   alu_res = '0;
        endcase
    end

    mdu_iter #(
        .WIDTH(WIDTH)
    ) u_mdu (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (mdu_start),
        .is_div_i   (is_div_op),
        .is_signed_i(dec.mdu_signed),
        .a_i        (src_a),
        .b_i        (src_b),
        .step_i     (mdu_step),
        .last_o     (mdu_last),
        .hi_o       (mdu_hi),
        .lo_o       (mdu_lo)
    );

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept && dec.ctrl == CTRL_MUL)      state_d = ST_MUL;
                else if (accept && dec.ctrl == CTRL_DIV) state_d = ST_DIV;
            end
            ST_MUL, ST_DIV: if (mdu_done) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs. A finishing MDU op parks on its last step while the
    // output register is still occupied, so HI/LO never move early.
    always_comb begin
        in_ready = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
        mdu_step = (state_q != ST_IDLE) && !(mdu_last && stall);
        mdu_done = (state_q != ST_IDLE) && mdu_last && !stall;
    end

    // Output register; zero is registered alongside result so it always
    // describes the held result and reads 0 out of reset.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        wr_en_d     = wr_en_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        if (accept && !is_mdu_op) begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            wr_en_d     = 1'b1;
            ovf_d       = alu_ovf;
            zero_d      = (alu_res == '0);
        end else if (mdu_done) begin
            out_valid_d = 1'b1;
            result_d    = mdu_lo;
            wr_en_d     = 1'b0;
            ovf_d       = 1'b0;
            zero_d      = (mdu_lo == '0);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            wr_en_q     <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            wr_en_q     <= wr_en_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            if (mdu_done) begin
                hi_q <= mdu_hi;
                lo_q <= mdu_lo;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign wr_en     = wr_en_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] src_a, src_b;
    logic        out_valid, out_ready;
    logic [31:0] result;
    logic        wr_en, zero, ovf;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .alu_op   (alu_op),
        .funct    (funct),
        .shamt    (shamt),
        .src_a    (src_a),
        .src_b    (src_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .result   (result),
        .wr_en    (wr_en),
        .zero     (zero),
        .ovf      (ovf)
    );

    int          n_pass = 0;
    int          n_total = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    logic [31:0] last_res;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic [5:0] fn_list [17] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                                 6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000010,
                                 6'b000011, 6'b010000, 6'b010010, 6'b011000, 6'b011001,
                                 6'b011010, 6'b011011};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    endtask

    // Reference behaviour from the instruction semantics; updates the HI/LO model.
    function automatic void model(input logic [1:0] op, input logic [5:0] fn, input logic [4:0] sh,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic w, output logic v, output int lat);
        logic [5:0]  f;
        longint      s;
        logic [63:0] p;
        int          sa, sb;
        f   = (op == 2'b10) ? fn : ((op == 2'b01) ? 6'b100010 : 6'b100000);
        w   = 1'b1;
        v   = 1'b0;
        lat = 1;
        r   = '0;
        sa  = a;
        sb  = b;
        case (f)
            6'b100010: begin
                s = longint'(sa) - longint'(sb);
                r = s[31:0];
                v = (s > SMAX) || (s < SMIN);
            end
            6'b100100: r = a & b;
            6'b100101: r = a | b;
            6'b100110: r = a ^ b;
            6'b100111: r = ~(a | b);
            6'b101010: r = (sa < sb) ? 32'd1 : 32'd0;
            6'b101011: r = (a < b) ? 32'd1 : 32'd0;
            6'b000000: r = b << sh;
            6'b000010: r = b >> sh;
            6'b000011: r = sb >>> sh;
            6'b010000: r = m_hi;
            6'b010010: r = m_lo;
            6'b011000, 6'b011001: begin
                if (f == 6'b011000) p = longint'(sa) * longint'(sb);
                else                p = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            6'b011010, 6'b011011: begin
                if (b == 32'd0) begin
                    m_lo = '1;
                    m_hi = a;
                end else if (f == 6'b011010 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = a;
                    m_hi = '0;
                end else if (f == 6'b011010) begin
                    m_lo = sa / sb;
                    m_hi = sa % sb;
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
            default: begin
                s = longint'(sa) + longint'(sb);
                r = s[31:0];
                v = (s > SMAX) || (s < SMIN);
            end
        endcase
        if (f inside {6'b011000, 6'b011001, 6'b011010, 6'b011011}) begin
            r   = m_lo;
            w   = 1'b0;
            lat = 33;
        end
    endfunction

    // Called #1 after a rising edge; returns #1 after the edge where out_valid is seen.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [5:0] fn,
                          input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er;
        logic        ew, ev;
        int          elat, lat, guard;
        model(op, fn, sh, a, b, er, ew, ev, elat);
        alu_op   = op;
        funct    = fn;
        shamt    = sh;
        src_a    = a;
        src_b    = b;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        last_res = result;
        chk({tag, "_latency"}, lat, elat);
        chk({tag, "_result"}, result, er);
        chk({tag, "_wr_en"}, {31'd0, wr_en}, {31'd0, ew});
        chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, ev});
        chk({tag, "_zero"}, {31'd0, zero}, {31'd0, (er == 32'd0)});
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        alu_op    = '0;
        funct     = '0;
        shamt     = '0;
        src_a     = '0;
        src_b     = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_zero", {31'd0, zero}, 32'd0);
        chk("rst_ovf", {31'd0, ovf}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("add_ovf", 2'b00, 6'b000000, 5'd0, 32'h7FFF_FFFF, 32'd1);
        chk("add_ovf_const", last_res, 32'h8000_0000);
        chk("add_ovf_flag", {31'd0, ovf}, 32'd1);
        run_op("slt", 2'b10, 6'b101010, 5'd0, 32'hFFFF_FFFF, 32'd1);
        chk("slt_const", last_res, 32'd1);
        run_op("sltu", 2'b10, 6'b101011, 5'd0, 32'hFFFF_FFFF, 32'd1);
        chk("sltu_const", last_res, 32'd0);
        run_op("sra", 2'b10, 6'b000011, 5'd4, 32'd0, 32'h8000_0000);
        chk("sra_const", last_res, 32'hF800_0000);
        run_op("sub_rsvd", 2'b11, 6'b100010, 5'd0, 32'd10, 32'd3);
        run_op("alu01_sub", 2'b01, 6'b100000, 5'd0, 32'h8000_0000, 32'd1);

        run_op("mult", 2'b10, 6'b011000, 5'd0, 32'hFFFF_FFFD, 32'd5);
        run_op("mflo", 2'b10, 6'b010010, 5'd0, 32'd0, 32'd0);
        chk("mflo_const", last_res, 32'hFFFF_FFF1);
        run_op("mfhi", 2'b10, 6'b010000, 5'd0, 32'd0, 32'd0);
        chk("mfhi_const", last_res, 32'hFFFF_FFFF);

        run_op("div", 2'b10, 6'b011010, 5'd0, 32'hFFFF_FFF9, 32'd2);
        chk("div_lo_const", last_res, 32'hFFFF_FFFD);
        run_op("div_hi", 2'b10, 6'b010000, 5'd0, 32'd0, 32'd0);
        run_op("div_minm1", 2'b10, 6'b011010, 5'd0, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_minm1_hi", 2'b10, 6'b010000, 5'd0, 32'd0, 32'd0);
        run_op("divu_zero", 2'b10, 6'b011011, 5'd0, 32'd7, 32'd0);
        chk("divu_zero_lo", last_res, 32'hFFFF_FFFF);
        run_op("divu_zero_hi", 2'b10, 6'b010000, 5'd0, 32'd0, 32'd0);
        chk("divu_zero_hi_const", last_res, 32'd7);

        // Backpressure: hold out_ready low for five cycles after an add.
        @(posedge clk); #1;
        out_ready = 1'b0;
        alu_op    = 2'b00;
        src_a     = 32'd5;
        src_b     = 32'd6;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        chk("bp_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_result", result, 32'd11);
        alu_op = 2'b01;
        src_a  = 32'd20;
        src_b  = 32'd3;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
            chk("bp_hold_result", result, 32'd11);
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_next_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_next_result", result, 32'd17);
        chk("bp_next_wr_en", {31'd0, wr_en}, 32'd1);

        // Reset in the middle of a multiply.
        alu_op   = 2'b10;
        funct    = 6'b011000;
        src_a    = 32'hFFFF_FFFD;
        src_b    = 32'd7;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mrst_result", result, 32'd0);
        chk("mrst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("mrst_zero", {31'd0, zero}, 32'd0);
        chk("mrst_ovf", {31'd0, ovf}, 32'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("mrst_mfhi", 2'b10, 6'b010000, 5'd0, 32'd0, 32'd0);
        chk("mrst_mfhi_const", last_res, 32'd0);
        run_op("mrst_mflo", 2'b10, 6'b010010, 5'd0, 32'd0, 32'd0);

        // Randomized ops against the reference model.
        for (int i = 0; i < 60; i++) begin
            logic [1:0] op;
            logic [5:0] fn;
            op = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
            fn = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fn_list[$urandom_range(0, 16)];
            run_op("rand", op, fn, 5'($urandom), rand_operand(), rand_operand());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
